round_robin_arbiter: RTL and testbench

- Parameterised round-robin arbiter that grants one of NUM_REQ requesters per cycle with rotating priority.
- Uses a masked/unmasked priority-encoder pair, with a thermometer priority mask held in a register.
- Sits between shared-resource requesters and the resource.
- Grant is registered, so it is valid one cycle after the request is sampled.

---
 rtl/round_robin_arbiter.sv | 99 +++++++++
 tb/tb_round_robin_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter
//   Rotating-priority arbiter for NUM_REQ requesters (legal range 2..32).
//   A thermometer mask register marks the high-priority window (requesters
//   above the last winner). The lowest requester inside the window wins;
//   if nobody in the window is requesting, the lowest requester overall wins.
//   The grant is registered, so it appears one cycle after req is sampled.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset (grant -> 0, mask -> all ones)
//   req       request vector, bit i = requester i wants the resource
//   mask      current priority mask register (1 = in high-priority window)
//   grant     registered one-hot grant, or zero
//   NextMask  value the mask register loads at the next edge
//
// Build option:
//   RRA_HOLD_GRANT_EN  when defined, a granted requester keeps the grant
//                      (and the mask is frozen) until its req bit drops.
module round_robin_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] mask,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] NextMask
);

  logic [NUM_REQ-1:0] masked_req;
  logic [NUM_REQ-1:0] masked_grant;
  logic [NUM_REQ-1:0] unmasked_grant;
  logic [NUM_REQ-1:0] arb_grant;
  logic [NUM_REQ-1:0] next_grant;
  logic [NUM_REQ-1:0] window;
  logic               masked_found;
  logic               unmasked_found;
  logic               seen;
  logic               hold;

`ifdef RRA_HOLD_GRANT_EN
  // Current winner still requesting: keep the grant and freeze rotation.
  assign hold = |(grant & req);
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    masked_req     = req & mask;
    masked_grant   = '0;
    unmasked_grant = '0;
    masked_found   = 1'b0;
    unmasked_found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!masked_found && masked_req[i]) begin
        masked_grant[i] = 1'b1;
        masked_found    = 1'b1;
      end
      if (!unmasked_found && req[i]) begin
        unmasked_grant[i] = 1'b1;
        unmasked_found    = 1'b1;
      end
    end
    arb_grant = masked_found ? masked_grant : unmasked_grant;

    // Thermometer window: every bit strictly above the winning bit.
    window = '0;
    seen   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      window[i] = seen;
      if (arb_grant[i]) begin
        seen = 1'b1;
      end
    end

    if (hold) begin
      next_grant = grant;
      NextMask   = mask;
    end else if (!unmasked_found) begin
      next_grant = '0;
      NextMask   = mask;
    end else begin
      next_grant = arb_grant;
      // Top requester won: the window above it is empty, so wrap to all ones.
      NextMask   = (window == '0) ? '1 : window;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant <= '0;
      mask  <= '1;
    end else begin
      grant <= next_grant;
      mask  <= NextMask;
    end
  end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Testbench for round_robin_arbiter with NUM_REQ = 4.
// Directed vector table plus short hand-written sequences for rotation
// fairness, bounded waiting and (when built with RRA_HOLD_GRANT_EN) the
// grant-hold behaviour.
module tb_round_robin_arbiter;

  localparam int unsigned N = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] mask;
  logic [N-1:0] grant;
  logic [N-1:0] next_mask;

  int n_vec;
  int n_bad;

  round_robin_arbiter #(.NUM_REQ(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .mask     (mask),
    .grant    (grant),
    .NextMask (next_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       chk_nm;
    logic [3:0] exp_nm;
    logic [3:0] exp_grant;
    logic [3:0] exp_mask;
  } vec_t;

  vec_t vecs [21];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act);
    n_vec++;
    if (act !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: got %b expected 1", name, act);
    end
  endtask

  // Drive inputs away from the edge, check NextMask before the edge,
  // then grant/mask just after it.
  task automatic step(input logic r, input logic [3:0] rq, input logic cnm,
                      input logic [3:0] enm, input logic [3:0] eg,
                      input logic [3:0] em, input string tag);
    @(negedge clk);
    rst = r;
    req = rq;
    #1;
    if (cnm) check({tag, ".nextmask"}, next_mask, enm);
    @(posedge clk);
    #1;
    check({tag, ".grant"}, grant, eg);
    check({tag, ".mask"}, mask, em);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst   = 1'b1;
    req   = '0;

`ifndef RRA_HOLD_GRANT_EN
    //           rst   req      chk   nm       grant    mask
    vecs[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b1111}; // reset
    vecs[1]  = '{1'b1, 4'b0000, 1'b1, 4'b1111, 4'b0000, 4'b1111};
    vecs[2]  = '{1'b0, 4'b0000, 1'b1, 4'b1111, 4'b0000, 4'b1111}; // idle after reset
    vecs[3]  = '{1'b0, 4'b0111, 1'b1, 4'b1110, 4'b0001, 4'b1110}; // rotation
    vecs[4]  = '{1'b0, 4'b0111, 1'b1, 4'b1100, 4'b0010, 4'b1100};
    vecs[5]  = '{1'b0, 4'b0111, 1'b1, 4'b1000, 4'b0100, 4'b1000};
    vecs[6]  = '{1'b0, 4'b0111, 1'b1, 4'b1110, 4'b0001, 4'b1110}; // unmasked fallback
    vecs[7]  = '{1'b0, 4'b0111, 1'b1, 4'b1100, 4'b0010, 4'b1100};
    vecs[8]  = '{1'b0, 4'b0101, 1'b1, 4'b1000, 4'b0100, 4'b1000}; // request change
    vecs[9]  = '{1'b0, 4'b0011, 1'b1, 4'b1110, 4'b0001, 4'b1110}; // masked empty
    vecs[10] = '{1'b0, 4'b0100, 1'b1, 4'b1000, 4'b0100, 4'b1000};
    vecs[11] = '{1'b0, 4'b1000, 1'b1, 4'b1111, 4'b1000, 4'b1111}; // wrap
    vecs[12] = '{1'b0, 4'b1001, 1'b1, 4'b1110, 4'b0001, 4'b1110};
    vecs[13] = '{1'b0, 4'b0010, 1'b1, 4'b1100, 4'b0010, 4'b1100};
    vecs[14] = '{1'b0, 4'b0000, 1'b1, 4'b1100, 4'b0000, 4'b1100}; // idle hold
    vecs[15] = '{1'b0, 4'b0000, 1'b1, 4'b1100, 4'b0000, 4'b1100};
    vecs[16] = '{1'b0, 4'b1111, 1'b1, 4'b1000, 4'b0100, 4'b1000};
    vecs[17] = '{1'b1, 4'b1111, 1'b1, 4'b1111, 4'b0000, 4'b1111}; // mid-op reset
    vecs[18] = '{1'b0, 4'b1111, 1'b1, 4'b1110, 4'b0001, 4'b1110};
    vecs[19] = '{1'b0, 4'b1111, 1'b1, 4'b1100, 4'b0010, 4'b1100};
    vecs[20] = '{1'b0, 4'b1000, 1'b1, 4'b1111, 4'b1000, 4'b1111};

    for (int i = 0; i < 21; i++) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].chk_nm, vecs[i].exp_nm,
           vecs[i].exp_grant, vecs[i].exp_mask, $sformatf("vec%0d", i));
    end

    // All four requesting: grants walk 0001,0010,0100,1000 and repeat.
    begin
      logic [3:0] e;
      step(1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b1111, "fair.rst");
      e = 4'b0001;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1111;
        @(posedge clk);
        #1;
        check($sformatf("fair%0d.grant", c), grant, e);
        e = {e[2:0], e[3]};
      end
    end

    // Requester 2 held high, others toggling: it must never wait N cycles,
    // and the grant must stay one-hot.
    begin
      int waited;
      step(1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b1111, "starve.rst");
      waited = 0;
      for (int c = 0; c < 24; c++) begin
        @(negedge clk);
        rst = 1'b0;
        req = 4'($urandom_range(0, 15)) | 4'b0100;
        @(posedge clk);
        #1;
        if (grant[2]) waited = 0;
        else waited++;
        check_bit($sformatf("starve%0d.wait", c), waited < int'(N));
        check_bit($sformatf("starve%0d.onehot", c), $onehot(grant));
      end
    end
`else
    // Hold mode: the winner keeps the grant while its req stays high.
    step(1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b1111, "hold.rst0");
    step(1'b1, 4'b0000, 1'b1, 4'b1111, 4'b0000, 4'b1111, "hold.rst1");
    step(1'b0, 4'b0011, 1'b1, 4'b1110, 4'b0001, 4'b1110, "hold.first");
    step(1'b0, 4'b0011, 1'b1, 4'b1110, 4'b0001, 4'b1110, "hold.keep0");
    step(1'b0, 4'b0011, 1'b1, 4'b1110, 4'b0001, 4'b1110, "hold.keep1");
    step(1'b0, 4'b0010, 1'b1, 4'b1100, 4'b0010, 4'b1100, "hold.drop");
    step(1'b0, 4'b1010, 1'b1, 4'b1100, 4'b0010, 4'b1100, "hold.keep2");
    step(1'b0, 4'b1000, 1'b1, 4'b1111, 4'b1000, 4'b1111, "hold.wrap");
    step(1'b1, 4'b1000, 1'b1, 4'b1111, 4'b0000, 4'b1111, "hold.midrst");
    step(1'b0, 4'b1001, 1'b1, 4'b1110, 4'b0001, 4'b1110, "hold.after");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
